mouse_cell_editor: RTL and testbench
====================================

Name: mouse_cell_editor

Overview:
- Sits directly downstream of the PS/2 mouse tracker.
- Converts its pixel cursor (x_pos/y_pos, left/right click levels) into a Game of Life grid cell address.
- Performs edits on the single-bit cell-state RAM through a req/gnt port arbitrated against the generation engine:
  - Left-click toggles the cell under the cursor, then drag-paints that value.
  - Right-click drag-erases.

Parameters:
- CELL_SHIFT, 2, log2 of cell size in pixels (4x4 px cells)
- GRID_W, 40, grid columns
- GRID_H, 30, grid rows
- ADDR_W, 11, cell RAM address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H

Ports:
- clock  in  1  system clock, same domain as the mouse tracker
- reset  in  1  synchronous, active-low
- x_pos  in  9  cursor X pixel
- y_pos  in  9  cursor Y pixel
- left_click  in  1  left button level
- right_click  in  1  right button level
- edit_enable  in  1  high = new edits may start (engine paused)
- mem_gnt  in  1  arbiter grant for the cell RAM
- mem_rdata  in  1  RAM read data; valid 1 cycle after address presented
- mem_req  out  1  RAM access request
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  1  RAM write data
- mem_we  out  1  RAM write strobe (single cycle)
- cursor_col  out  6  x_pos >> CELL_SHIFT
- cursor_row  out  6  y_pos >> CELL_SHIFT
- cursor_valid  out  1  col < GRID_W and row < GRID_H
- busy  out  1  FSM not in IDLE
- edit_count  out  16  total writes performed; wraps at 65535 -> 0

Behaviour:
- Reset values: all outputs 0. The following internal state is cleared:
  - FSM = IDLE
  - prev_left, prev_right, pending_toggle = 0
  - last_valid = 0, paint_val = 0
- cursor_col, cursor_row and cursor_valid are registered; they update one cycle after x_pos/y_pos.
- Cursor address = cursor_row*GRID_W + cursor_col, computed at ADDR_W width with no truncation.
- Edge detect: the registers prev_left and prev_right sample the click levels every cycle.
- Left rising edge (left=1, prev_left=0) with cursor_valid sets pending_toggle. This happens in any state, so an edge arriving while busy is not lost.
- Operation selection in IDLE, only when edit_enable=1. Priority order:
  1. TOGGLE: pending_toggle=1. Clear pending_toggle; latch op_addr.
  2. PAINT: left held, cursor_valid, and (last_valid=0 or addr != last_addr). Write paint_val.
  3. ERASE: right held, left not held, cursor_valid, and (last_valid=0 or addr != last_addr). Write 0.
- Left and right pressed together: left wins; right is ignored while left is held.
- FSM states: IDLE, REQ, READ, RWAIT, WRITE.
  - IDLE -> REQ on any selected operation.
  - REQ: mem_req=1; hold until mem_gnt=1. Then TOGGLE -> READ, PAINT/ERASE -> WRITE.
  - READ: mem_addr=op_addr -> RWAIT.
  - RWAIT: capture mem_rdata; set paint_val = ~mem_rdata -> WRITE.
  - WRITE: mem_we=1; mem_wdata = paint_val for TOGGLE/PAINT, 0 for ERASE. Increment edit_count; last_addr=op_addr; last_valid=1 -> IDLE.
- Bus outputs outside IDLE:
  - mem_req stays 1 in REQ, READ, RWAIT and WRITE; it drops in IDLE.
  - mem_addr holds op_addr in every non-IDLE state.
  - mem_gnt is sampled only in REQ; once granted, the operation completes regardless of mem_gnt.
- Latency with mem_gnt tied high, event in IDLE at cycle N:
  - TOGGLE: mem_we=1 at N+4.
  - PAINT/ERASE: mem_we=1 at N+2.
- A falling edge of the controlling button (left for paint, right for erase) clears last_valid, so the next press may edit the same cell again.
- Cursor invalid (off-grid): no new operation starts; an in-flight operation completes. A left edge while the cursor is invalid is ignored.
- edit_enable:
  - Dropping to 0 mid-operation does not abort the operation.
  - While 0, pending_toggle is retained and serviced once edit_enable returns to 1.
- Reset mid-operation: the next cycle is IDLE with mem_req=0 and mem_we=0; no partial write occurs.

Test Plan:
- Toggle: gnt=1, cell (3,2)=0, x=13,y=9, left pulse -> op_addr=83, mem_we=1 for exactly one cycle 4 cycles after the edge, wdata=1, edit_count=1.
- Drag paint: hold left from (0,0) whose RAM=1, move x 0->4->8 px -> writes at addrs 0 (wdata 0), 1 (wdata 0), 2 (wdata 0); no repeated write while stationary.
- Erase and priority:
  - Right held sweeping cols 5..7 on row 0 -> three writes of 0 to addrs 5,6,7.
  - Left+right rising together -> toggle only.
- Arbitration: gnt=0 for 20 cycles after left edge -> mem_req=1 throughout, no mem_we. gnt=1 -> write follows 3 cycles later.
- Boundaries:
  - x=160 (col 40) -> cursor_valid=0; click produces no request.
  - edit_enable=0 click -> nothing until enable=1, then exactly one toggle.
  - edit_count at 65535 + one write -> 0.
- Reset asserted in RWAIT -> next cycle IDLE, mem_req=0, mem_we never pulses; all outputs 0.

Source files
------------

// File: rtl/mouse_cell_editor_if.sv
// Cell-RAM port shared with the generation engine through an external req/gnt arbiter.
interface mouse_cell_editor_if #(parameter int ADDR_W = 11);
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wdata;
  logic              mem_we;
  logic              mem_rdata;

  modport master (output mem_req, mem_addr, mem_wdata, mem_we, input mem_gnt, mem_rdata);
  modport slave  (input mem_req, mem_addr, mem_wdata, mem_we, output mem_gnt, mem_rdata);
endinterface

// File: rtl/mouse_cell_editor.sv
// Maps the mouse cursor onto a Life grid cell and performs toggle / drag-paint /
// drag-erase edits on the single-bit cell RAM.
module mouse_cell_editor #(
  parameter int CELL_SHIFT = 2,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int ADDR_W     = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [8:0]          x_pos,
  input  logic [8:0]          y_pos,
  input  logic                left_click,
  input  logic                right_click,
  input  logic                edit_enable,
  mouse_cell_editor_if.master mem,
  output logic [5:0]          cursor_col,
  output logic [5:0]          cursor_row,
  output logic                cursor_valid,
  output logic                busy,
  output logic [15:0]         edit_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] RWAIT = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  localparam logic [1:0] OP_TOGGLE = 2'd0;
  localparam logic [1:0] OP_PAINT  = 2'd1;
  localparam logic [1:0] OP_ERASE  = 2'd2;

  logic [2:0]        state;
  logic [1:0]        op;
  logic [ADDR_W-1:0] op_addr, last_addr, cur_addr;
  logic              prev_left, prev_right, pending_toggle, last_valid, paint_val;
  logic [8:0]        col_full, row_full;
  logic              left_rise, left_fall, right_fall, addr_new, paint_ok, erase_ok;

  // Validity uses the full shifted value so large pixels never alias onto the grid.
  assign col_full = x_pos >> CELL_SHIFT;
  assign row_full = y_pos >> CELL_SHIFT;
  assign cur_addr = ADDR_W'(cursor_row) * ADDR_W'(GRID_W) + ADDR_W'(cursor_col);

  assign left_rise  = left_click & ~prev_left;
  assign left_fall  = ~left_click & prev_left;
  assign right_fall = ~right_click & prev_right;
  assign addr_new   = ~last_valid | (cur_addr != last_addr);
  // The press cycle itself belongs to the toggle, so painting needs left held for two samples.
  assign paint_ok   = left_click & prev_left & cursor_valid & addr_new;
  assign erase_ok   = right_click & ~left_click & cursor_valid & addr_new;

  assign busy          = (state != IDLE);
  assign mem.mem_req   = busy;
  assign mem.mem_addr  = busy ? op_addr : '0;
  assign mem.mem_we    = (state == WRITE);
  assign mem.mem_wdata = (state == WRITE) && (op != OP_ERASE) ? paint_val : 1'b0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      op             <= OP_TOGGLE;
      op_addr        <= '0;
      last_addr      <= '0;
      prev_left      <= 1'b0;
      prev_right     <= 1'b0;
      pending_toggle <= 1'b0;
      last_valid     <= 1'b0;
      paint_val      <= 1'b0;
      cursor_col     <= '0;
      cursor_row     <= '0;
      cursor_valid   <= 1'b0;
      edit_count     <= '0;
    end else begin
      prev_left    <= left_click;
      prev_right   <= right_click;
      cursor_col   <= col_full[5:0];
      cursor_row   <= row_full[5:0];
      cursor_valid <= (col_full < 9'(GRID_W)) && (row_full < 9'(GRID_H));

      case (state)
        IDLE: if (edit_enable && cursor_valid) begin
          if (pending_toggle) begin
            pending_toggle <= 1'b0;
            op             <= OP_TOGGLE;
            op_addr        <= cur_addr;
            state          <= REQ;
          end else if (paint_ok) begin
            op      <= OP_PAINT;
            op_addr <= cur_addr;
            state   <= REQ;
          end else if (erase_ok) begin
            op      <= OP_ERASE;
            op_addr <= cur_addr;
            state   <= REQ;
          end
        end
        REQ:   if (mem.mem_gnt) state <= (op == OP_TOGGLE) ? READ : WRITE;
        READ:  state <= RWAIT;
        RWAIT: begin
          paint_val <= ~mem.mem_rdata;
          state     <= WRITE;
        end
        WRITE: begin
          edit_count <= edit_count + 16'd1;
          last_addr  <= op_addr;
          last_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed after the case so a fresh edge outranks servicing of the previous one.
      if (left_rise && cursor_valid) pending_toggle <= 1'b1;
      if (left_fall || (right_fall && !left_click)) last_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mouse_cell_editor.sv
// Directed bench for mouse_cell_editor with a behavioural 1-cycle-latency cell RAM.
module tb_mouse_cell_editor;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  x_pos = '0, y_pos = '0;
  logic        left_click = 1'b0, right_click = 1'b0, edit_enable = 1'b1;
  logic [5:0]  cursor_col, cursor_row;
  logic        cursor_valid, busy;
  logic [15:0] edit_count;

  mouse_cell_editor_if #(.ADDR_W(11)) mem_bus();

  mouse_cell_editor #(.CELL_SHIFT(2), .GRID_W(40), .GRID_H(30), .ADDR_W(11)) dut (
    .clock(clock), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .left_click(left_click), .right_click(right_click), .edit_enable(edit_enable),
    .mem(mem_bus), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cursor_valid(cursor_valid), .busy(busy), .edit_count(edit_count)
  );

  always #5 clock = ~clock;

  bit         ram [0:2047];
  logic [10:0] wq_a[$];
  logic        wq_d[$];

  always @(posedge clock) begin
    mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
    if (mem_bus.mem_we) begin
      ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      wq_a.push_back(mem_bus.mem_addr);
      wq_d.push_back(mem_bus.mem_wdata);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic watch(input int n, output int first, output int nwe,
                       output logic [10:0] wa, output logic wd,
                       output logic req_all, output logic busy_any);
    first = 0; nwe = 0; wa = '0; wd = 1'b0; req_all = 1'b1; busy_any = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (mem_bus.mem_we) begin
        nwe++;
        if (first == 0) begin
          first = i;
          wa = mem_bus.mem_addr;
          wd = mem_bus.mem_wdata;
        end
      end
      req_all  &= mem_bus.mem_req;
      busy_any |= busy;
    end
  endtask

  int          first, nwe, base;
  logic [10:0] wa;
  logic        wd, req_all, busy_any;

  initial begin
    mem_bus.mem_gnt = 1'b1;
    repeat (3) tick();
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_we", mem_bus.mem_we, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", edit_count, 0);
    chk("rst_valid", cursor_valid, 0);
    reset = 1'b1;

    // toggle cell (3,2) -> addr 83, write 1 four cycles after the edge
    x_pos = 9'd13; y_pos = 9'd9;
    repeat (2) tick();
    chk("cur_col", cursor_col, 3);
    chk("cur_row", cursor_row, 2);
    chk("cur_valid", cursor_valid, 1);
    left_click = 1'b1;
    watch(8, first, nwe, wa, wd, req_all, busy_any);
    chk("tgl_lat", first, 5);
    chk("tgl_nwe", nwe, 1);
    chk("tgl_addr", wa, 83);
    chk("tgl_wd", wd, 1);
    chk("tgl_count", edit_count, 1);
    watch(5, first, nwe, wa, wd, req_all, busy_any);
    chk("tgl_hold_nwe", nwe, 0);
    left_click = 1'b0;
    repeat (2) tick();

    // drag paint: set cell 0 to 1, then press on it and drag right
    x_pos = 9'd0; y_pos = 9'd0;
    repeat (2) tick();
    left_click = 1'b1; watch(8, first, nwe, wa, wd, req_all, busy_any);
    left_click = 1'b0; watch(3, first, nwe, wa, wd, req_all, busy_any);
    base = wq_a.size();
    left_click = 1'b1; watch(8, first, nwe, wa, wd, req_all, busy_any);
    x_pos = 9'd4;      watch(6, first, nwe, wa, wd, req_all, busy_any);
    x_pos = 9'd8;      watch(6, first, nwe, wa, wd, req_all, busy_any);
    watch(6, first, nwe, wa, wd, req_all, busy_any);
    chk("paint_still_nwe", nwe, 0);
    left_click = 1'b0; repeat (2) tick();
    chk("paint_nwr", wq_a.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < wq_a.size()) begin
        chk($sformatf("paint_a%0d", k), wq_a[base+k], k);
        chk($sformatf("paint_d%0d", k), wq_d[base+k], 0);
      end
    end

    // erase sweep over cols 5..7 on row 0
    x_pos = 9'd20; repeat (2) tick();
    base = wq_a.size();
    right_click = 1'b1; watch(6, first, nwe, wa, wd, req_all, busy_any);
    x_pos = 9'd24;      watch(6, first, nwe, wa, wd, req_all, busy_any);
    x_pos = 9'd28;      watch(6, first, nwe, wa, wd, req_all, busy_any);
    right_click = 1'b0; repeat (2) tick();
    chk("erase_nwr", wq_a.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < wq_a.size()) begin
        chk($sformatf("erase_a%0d", k), wq_a[base+k], 5 + k);
        chk($sformatf("erase_d%0d", k), wq_d[base+k], 0);
      end
    end

    // both buttons together at (10,10) -> single toggle of addr 410
    x_pos = 9'd40; y_pos = 9'd40; repeat (2) tick();
    left_click = 1'b1; right_click = 1'b1;
    watch(10, first, nwe, wa, wd, req_all, busy_any);
    chk("both_nwe", nwe, 1);
    chk("both_addr", wa, 410);
    chk("both_wd", wd, 1);
    left_click = 1'b0; right_click = 1'b0; repeat (2) tick();

    // arbitration stall on cell 83 (currently 1)
    x_pos = 9'd13; y_pos = 9'd9; repeat (2) tick();
    mem_bus.mem_gnt = 1'b0;
    left_click = 1'b1;
    watch(2, first, nwe, wa, wd, req_all, busy_any);
    watch(20, first, nwe, wa, wd, req_all, busy_any);
    chk("arb_req_held", req_all, 1);
    chk("arb_nwe", nwe, 0);
    mem_bus.mem_gnt = 1'b1;
    watch(6, first, nwe, wa, wd, req_all, busy_any);
    chk("arb_lat", first, 3);
    chk("arb_addr", wa, 83);
    chk("arb_wd", wd, 0);
    left_click = 1'b0; repeat (2) tick();

    // off-grid column 40
    x_pos = 9'd160; y_pos = 9'd0; repeat (2) tick();
    chk("off_col", cursor_col, 40);
    chk("off_valid", cursor_valid, 0);
    left_click = 1'b1;
    watch(8, first, nwe, wa, wd, req_all, busy_any);
    chk("off_busy", busy_any, 0);
    chk("off_nwe", nwe, 0);
    left_click = 1'b0; repeat (2) tick();

    // click while disabled is held until enable returns
    x_pos = 9'd0; y_pos = 9'd4; edit_enable = 1'b0; repeat (2) tick();
    left_click = 1'b1; watch(3, first, nwe, wa, wd, req_all, busy_any);
    left_click = 1'b0; watch(10, first, nwe, wa, wd, req_all, busy_any);
    chk("dis_busy", busy_any, 0);
    edit_enable = 1'b1;
    watch(10, first, nwe, wa, wd, req_all, busy_any);
    chk("en_nwe", nwe, 1);
    chk("en_addr", wa, 40);
    chk("en_wd", wd, 1);

    // write counter wrap
    chk("count_total", edit_count, 11);
    force dut.edit_count = 16'hFFFF;
    #1;
    release dut.edit_count;
    tick();
    chk("count_preload", edit_count, 16'hFFFF);
    left_click = 1'b1; watch(8, first, nwe, wa, wd, req_all, busy_any);
    chk("wrap_nwe", nwe, 1);
    chk("wrap_count", edit_count, 0);
    left_click = 1'b0; repeat (2) tick();

    // reset while waiting for read data
    x_pos = 9'd0; y_pos = 9'd8; repeat (2) tick();
    left_click = 1'b1;
    watch(4, first, nwe, wa, wd, req_all, busy_any);
    chk("rw_busy", busy, 1);
    chk("rw_addr", mem_bus.mem_addr, 80);
    base = wq_a.size();
    reset = 1'b0;
    tick();
    chk("rr_busy", busy, 0);
    chk("rr_req", mem_bus.mem_req, 0);
    chk("rr_we", mem_bus.mem_we, 0);
    chk("rr_addr", mem_bus.mem_addr, 0);
    chk("rr_count", edit_count, 0);
    chk("rr_valid", cursor_valid, 0);
    left_click = 1'b0;
    tick();
    reset = 1'b1;
    watch(8, first, nwe, wa, wd, req_all, busy_any);
    chk("rr_after_busy", busy_any, 0);
    chk("rr_nwr", wq_a.size() - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
